// File: rtl/mul_sequencer_if.sv
// Issue/result bus for the sequential 64-bit multiplier.
// The control side drives start/flush/operands; the multiplier drives
// stall/busy/done/result.
interface mul_sequencer_if;
    logic        start;
    logic        flush;
    logic [63:0] opA;
    logic [63:0] opB;
    logic        stall;
    logic        busy;
    logic        done;
    logic [63:0] result;

    modport master (
        output start,
        output flush,
        output opA,
        output opB,
        input  stall,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  flush,
        input  opA,
        input  opB,
        output stall,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/mul_sequencer.sv
// Sequential shift-add multiplier: one partial product per BUSY cycle,
// low 64 bits of opA*opB (identical for signed and unsigned operands).
// Optional feature macro: MUL_EARLY_TERM_EN -- finish as soon as the
// remaining multiplier bits are all zero instead of always taking 64 steps.
module mul_sequencer (
    input  logic          clk,
    input  logic          reset,
    mul_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [63:0] r_mcd;
    logic [63:0] r_mlr;
    logic [63:0] r_acc;
    logic [63:0] r_result;
    logic [5:0]  r_count;
    logic        r_busy;
    logic        r_done;

    logic [63:0] w_acc_next;
    logic [63:0] w_mcd_next;
    logic [63:0] w_mlr_next;
    logic        w_last;
    logic        w_issue;

    // One shift-add step and the decision whether it is the final one
    always_comb begin
        w_acc_next = r_mlr[0] ? (r_acc + r_mcd) : r_acc;
        w_mcd_next = {r_mcd[62:0], 1'b0};
        w_mlr_next = {1'b0, r_mlr[63:1]};
`ifdef MUL_EARLY_TERM_EN
        w_last     = (r_count == 6'd63) || (w_mlr_next == 64'd0);
`else
        w_last     = (r_count == 6'd63);
`endif
    end

    // A start only counts in IDLE and loses to a simultaneous flush
    assign w_issue = (r_state == S_IDLE) && bus.start && !bus.flush;

    // Sequencer FSM with operand/accumulator datapath and registered status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_mcd    <= 64'd0;
            r_mlr    <= 64'd0;
            r_acc    <= 64'd0;
            r_result <= 64'd0;
            r_count  <= 6'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    if (w_issue) begin
                        r_mcd   <= bus.opA;
                        r_mlr   <= bus.opB;
                        r_acc   <= 64'd0;
                        r_count <= 6'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (bus.flush) begin
                        // Squashed: drop the work, keep the previous result
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc   <= w_acc_next;
                        r_mcd   <= w_mcd_next;
                        r_mlr   <= w_mlr_next;
                        r_count <= r_count + 6'd1;
                        if (w_last) begin
                            r_result <= w_acc_next;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Front-end freeze covers the issue cycle, all BUSY cycles and DONE
    assign bus.stall  = reset && ((r_state != S_IDLE) || w_issue);
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed corner cases plus random
// operands against a plain-arithmetic reference model.
module tb_mul_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
    logic [63:0] exp_res;

    always #5 clk = ~clk;

    mul_sequencer_if bus ();

    mul_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Expected number of BUSY cycles for a given multiplier
    function automatic int exp_busy_len(input logic [63:0] b);
        int len = 1;
        for (int i = 0; i < 64; i++) if (b[i]) len = i + 1;
`ifndef MUL_EARLY_TERM_EN
        len = 64;
`endif
        return len;
    endfunction

    task automatic run_mul(input logic [63:0] a, input logic [63:0] b, input string tag);
        int nb = 0;
        int ns = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b0; bus.opA = a; bus.opB = b;
        #1;
        check_val({tag, "_issue_stall"}, 64'(bus.stall), 64'd1);
        if (bus.stall) ns++;
        @(negedge clk);
        bus.start = 1'b0; bus.opA = rand64(); bus.opB = rand64();
        while (bus.busy && nb < 200) begin
            if (bus.stall) ns++;
            nb++;
            @(negedge clk);
        end
        if (bus.stall) ns++;
        exp_res = a * b;
        check_val({tag, "_busy_len"}, 64'(nb), 64'(exp_busy_len(b)));
        check_val({tag, "_stall_len"}, 64'(ns), 64'(exp_busy_len(b) + 2));
        check_val({tag, "_done"}, 64'(bus.done), 64'd1);
        check_val({tag, "_result"}, bus.result, exp_res);
        @(negedge clk);
        check_val({tag, "_done_clear"}, 64'(bus.done), 64'd0);
        check_val({tag, "_idle_stall"}, 64'(bus.stall), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n_done;
        int pc;
        logic [63:0] a, b;
        reset = 1'b0;
        bus.start = 1'b0; bus.flush = 1'b0; bus.opA = '0; bus.opB = '0;
        exp_res = 64'd0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        #1;
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        check_val("rst_done", 64'(bus.done), 64'd0);
        check_val("rst_stall", 64'(bus.stall), 64'd0);
        check_val("rst_result", bus.result, 64'd0);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Directed arithmetic cases
        run_mul(64'd3, 64'd5, "basic");
        run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, "neg");
        run_mul(64'h1_0000_0000, 64'h1_0000_0000, "ovf");

        // Start re-pulsed while busy must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.opA = 64'd7; bus.opB = 64'd6;
        @(negedge clk);
        bus.start = 1'b0;
        pc = (exp_busy_len(64'd6) >= 21) ? 20 : 2;
        repeat (pc - 1) @(negedge clk);
        check_val("rearm_in_busy", 64'(bus.busy), 64'd1);
        bus.start = 1'b1; bus.opA = 64'd9; bus.opB = rand64();
        @(negedge clk);
        bus.start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 150; i++) begin
            if (bus.done) n_done++;
            @(negedge clk);
        end
        exp_res = 64'd42;
        check_val("rearm_done_cnt", 64'(n_done), 64'd1);
        check_val("rearm_result", bus.result, exp_res);

        // Flush while busy: back to IDLE, no done, result unchanged
        bus.start = 1'b1; bus.opA = 64'd4; bus.opB = 64'd4;
        @(negedge clk);
        bus.start = 1'b0;
        pc = (exp_busy_len(64'd4) >= 11) ? 10 : 2;
        repeat (pc - 1) @(negedge clk);
        check_val("flush_in_busy", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check_val("flush_busy", 64'(bus.busy), 64'd0);
        check_val("flush_stall", 64'(bus.stall), 64'd0);
        n_done = 0;
        for (int i = 0; i < 80; i++) begin
            if (bus.done) n_done++;
            @(negedge clk);
        end
        check_val("flush_done_cnt", 64'(n_done), 64'd0);
        check_val("flush_result", bus.result, exp_res);

        // Simultaneous start and flush in IDLE: start dropped
        bus.start = 1'b1; bus.flush = 1'b1; bus.opA = 64'd11; bus.opB = 64'd13;
        #1;
        check_val("sf_stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        check_val("sf_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check_val("sf_done", 64'(bus.done), 64'd0);

        // Reset in the middle of a multiply
        bus.start = 1'b1; bus.opA = 64'd5; bus.opB = 64'h8000_0000_0000_0003;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (29) @(negedge clk);
        check_val("mrst_in_busy", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        bus.start = 1'b1;
        #1;
        exp_res = 64'd0;
        check_val("mrst_busy", 64'(bus.busy), 64'd0);
        check_val("mrst_done", 64'(bus.done), 64'd0);
        check_val("mrst_stall", 64'(bus.stall), 64'd0);
        check_val("mrst_result", bus.result, exp_res);
        @(negedge clk);
        bus.start = 1'b0;
        reset = 1'b1;
        run_mul(64'd2, 64'd2, "post_rst");

        // Latency-sensitive multipliers
        run_mul(rand64(), 64'd1, "et_one");
        run_mul(rand64(), 64'd0, "et_zero");
        run_mul(rand64(), 64'h80, "et_80");

        // Random operands with varied multiplier widths
        for (int i = 0; i < 12; i++) begin
            a = rand64();
            b = rand64() >> $urandom_range(0, 63);
            run_mul(a, b, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
